logic_cut_exerciser: RTL

//   Self-test driver/checker for the 3-input AND/OR/NOT logic block:
//   x = (A & B) | ~C, y = ~C. Drives A,B,C into the block under test
//   and checks its x,y responses. Exhaustively walks all 8 input vectors.

---
 rtl/logic_cut_exerciser.sv | 129 ++++++++++++
 1 files changed

// File: rtl/logic_cut_exerciser.sv
// Self-test driver/checker for the (A&B)|~C, ~C logic block: walks all 8 input
// vectors, waits a settle time per vector, and records mismatches.
module logic_cut_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] stim_o,
  input  logic [1:0] resp_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] first_fail_vec
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);
  // With no settle time each vector is checked on the cycle it is applied.
  localparam logic [1:0] VecState   = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;

  logic [1:0] state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic       fv_q, fv_d;
  logic [2:0] ffv_q, ffv_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [1:0] expected;
  logic       mismatch;

  assign expected = {~vec_q[2], (vec_q[0] & vec_q[1]) | ~vec_q[2]};
  assign mismatch = (resp_i != expected);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ffv_d   = ffv_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 4'd0;
          fv_d    = 1'b0;
          ffv_d   = 3'd0;
          pass_d  = 1'b0;
          vec_d   = 3'd0;
          cnt_d   = SettleInit;
          busy_d  = 1'b1;
          state_d = VecState;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + 4'd1;
          if (!fv_q) begin
            fv_d  = 1'b1;
            ffv_d = vec_q;
          end
        end
        if (vec_q == 3'd7) begin
          pass_d  = (err_d == 4'd0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 3'd1;
          cnt_d   = SettleInit;
          state_d = VecState;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= 4'd0;
      err_q   <= 4'd0;
      fv_q    <= 1'b0;
      ffv_q   <= 3'd0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign stim_o         = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fv_q;
  assign first_fail_vec = ffv_q;

endmodule
